muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative multiply/divide unit with a sequencing FSM and the architectural HI/LO registers.
- Serves MULT/MULTU/DIV/DIVU/MTHI/MTLO for the execute stage, beside the single-cycle ALU.
- Holds the pipeline via busy while iterating; the execute stage reads hi/lo for MFHI/MFLO.

Parameters:
- None. Width is fixed at `CPU_REG_WIDTH` (32). Op codes are defined in cpu_const.vh as `CPU_MDOP_*`, 3 bits wide.
- Op encoding: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; 7 is reserved and treated as NONE.

Ports:
clk  input  1  clock, all state updates on rising edge
nrst  input  1  asynchronous active-low reset
md_op  input  3  operation code `CPU_MDOP_*`, qualified by md_start
md_start  input  1  request strobe, sampled only while busy=0
rs  input  32  multiplicand / dividend / MTHI-MTLO source
rt  input  32  multiplier / divisor
cancel  input  1  abort in-flight operation (exception/flush)
busy  output  1  iteration in progress; pipeline must stall MFHI/MFLO and md ops
done  output  1  one-cycle pulse when HI/LO are updated by MULT/DIV
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (nrst=0, asynchronous): state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0. Reset mid-operation discards the operation with no partial HI/LO write.
- States: IDLE, MUL, DIV, FIX.
- IDLE, md_start=1:
  - MTHI: hi<=rs at the next edge; busy stays 0; done stays 0.
  - MTLO: lo<=rs at the next edge; busy stays 0; done stays 0.
  - MULT/MULTU: latch |rs| and |rt| (signed ops) or the raw values (unsigned), plus result sign = rs[31]^rt[31] (signed only). Counter=0, go to MUL.
  - DIV/DIVU: latch |rs| and |rt| (or raw), quotient sign = rs[31]^rt[31], remainder sign = rs[31]. Go to DIV.
  - NONE/reserved: no effect.
- MUL: radix-2 shift-add over a 64-bit accumulator; one multiplier bit per cycle; 32 cycles, then FIX.
- DIV: restoring division, one quotient bit per cycle; 32 cycles, then FIX.
  - Divisor 0: the iteration runs normally and yields quotient=FFFFFFFF and remainder=dividend magnitude.
  - For DIV by 0, sign fixup is skipped: lo=FFFFFFFF, hi=rs.
- FIX (1 cycle):
  - Apply two's-complement negation where the sign flag is set.
  - MUL: negate the full 64 bits.
  - DIV: negate quotient and remainder independently.
  - Write {hi,lo} (MUL) or hi=remainder, lo=quotient (DIV); pulse done=1; return to IDLE.
- Latency: md_start accepted at edge N; busy=1 from N+1 through N+33; hi/lo and done valid at N+34 (busy=0 that cycle). A new md_start is accepted in the cycle done is high.
- Signed overflow case: DIV 80000000/FFFFFFFF gives lo=80000000, hi=0, falling out of the magnitude arithmetic with no special path.
- busy=1: md_start is ignored, including MTHI/MTLO; the pipeline guarantees it is not asserted.
- cancel=1 in MUL/DIV/FIX: return to IDLE at the next edge; hi/lo unchanged; done not pulsed. cancel in IDLE has no effect. cancel and md_start in the same IDLE cycle: cancel wins and the request is dropped.
- Outputs busy and done are registered. hi/lo are driven directly from their registers.

Test Plan:
- MULT rs=FFFFFFFD (-3), rt=00000007 -> busy high exactly 33 cycles, done pulse; hi=FFFFFFFF, lo=FFFFFFEB.
- MULTU rs=FFFFFFFF, rt=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; then MULT with the same operands -> hi=00000000, lo=00000001.
- DIV rs=FFFFFFF9 (-7), rt=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU same operands -> lo=7FFFFFFC, hi=00000001.
- DIV 80000000/FFFFFFFF -> lo=80000000, hi=0. DIVU 12345678/0 -> lo=FFFFFFFF, hi=12345678.
- MTHI AAAA5555 then MTLO 5555AAAA -> each written next cycle with busy=0; MTHI issued while busy -> ignored, hi unchanged.
- Start MULT, assert cancel at iteration 10 -> busy drops next cycle, no done, hi/lo keep prior values. Repeat with nrst pulsed low mid-DIV -> hi=lo=0 and busy=0 immediately.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// MULT/DIV take 32 shift-add / restoring-divide iterations plus one sign-fixup cycle.
module muldiv_seq (
  input  logic        clk,
  input  logic        nrst,
  input  logic [2:0]  md_op,
  input  logic        md_start,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      state, state_nxt;
  logic [63:0] acc;
  logic [31:0] opb;
  logic [4:0]  cnt;
  logic        neg_q, neg_r, is_div;

  logic        accept, start_mul, start_div, wr_hi, wr_lo;
  logic        last_iter, busy_nxt, done_nxt;
  logic        op_signed;
  logic [31:0] rs_mag, rt_mag;

  logic [32:0] mul_sum;
  logic [32:0] div_shift, div_trial;
  logic        div_ok;
  logic [63:0] mul_res;
  logic [31:0] q_res, r_res;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start_mul)      state_nxt = S_MUL;
        else if (start_div) state_nxt = S_DIV;
      end
      S_MUL: begin
        if (cancel)         state_nxt = S_IDLE;
        else if (last_iter) state_nxt = S_FIX;
      end
      S_DIV: begin
        if (cancel)         state_nxt = S_IDLE;
        else if (last_iter) state_nxt = S_FIX;
      end
      S_FIX:                state_nxt = S_IDLE;
      default:              state_nxt = S_IDLE;
    endcase
  end

  // ---------------- output / control decode ----------------
  always_comb begin
    accept    = (state == S_IDLE) && md_start && !cancel;
    start_mul = accept && ((md_op == OP_MULT) || (md_op == OP_MULTU));
    start_div = accept && ((md_op == OP_DIV)  || (md_op == OP_DIVU));
    wr_hi     = accept && (md_op == OP_MTHI);
    wr_lo     = accept && (md_op == OP_MTLO);
    last_iter = (cnt == 5'd31);
    busy_nxt  = (state_nxt != S_IDLE);
    done_nxt  = (state == S_FIX) && !cancel;
  end

  // ---------------- datapath helpers ----------------
  always_comb begin
    op_signed = (md_op == OP_MULT) || (md_op == OP_DIV);
    rs_mag    = (op_signed && rs[31]) ? (~rs + 32'd1) : rs;
    rt_mag    = (op_signed && rt[31]) ? (~rt + 32'd1) : rt;

    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);

    // acc[63:32] is the partial remainder, acc[31:0] shifts dividend bits out and quotient bits in
    div_shift = {acc[63:32], acc[31]};
    div_trial = div_shift - {1'b0, opb};
    div_ok    = !div_trial[32];

    mul_res   = neg_q ? (~acc + 64'd1) : acc;
    q_res     = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
    r_res     = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
  end

  // ---------------- datapath and registered outputs ----------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc    <= '0;
      opb    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_div <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      if (wr_hi) hi <= rs;
      if (wr_lo) lo <= rs;
      if (start_mul) begin
        acc    <= {32'd0, rt_mag};
        opb    <= rs_mag;
        cnt    <= '0;
        neg_q  <= op_signed && (rs[31] ^ rt[31]);
        neg_r  <= 1'b0;
        is_div <= 1'b0;
      end else if (start_div) begin
        acc    <= {32'd0, rs_mag};
        opb    <= rt_mag;
        cnt    <= '0;
        // a zero divisor keeps the all-ones quotient unsigned
        neg_q  <= op_signed && (rs[31] ^ rt[31]) && (rt != 32'd0);
        neg_r  <= op_signed && rs[31];
        is_div <= 1'b1;
      end
      case (state)
        S_MUL: begin
          acc <= {mul_sum, acc[31:1]};
          cnt <= cnt + 5'd1;
        end
        S_DIV: begin
          acc <= {(div_ok ? div_trial[31:0] : div_shift[31:0]), acc[30:0], div_ok};
          cnt <= cnt + 5'd1;
        end
        S_FIX: begin
          if (!cancel) begin
            if (is_div) begin
              hi <= r_res;
              lo <= q_res;
            end else begin
              hi <= mul_res[63:32];
              lo <= mul_res[31:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed cases plus randomized MULT/DIV traffic
// compared against plain-arithmetic reference results.
module tb_muldiv_seq;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        nrst;
  logic [2:0]  md_op;
  logic        md_start;
  logic [31:0] rs, rt;
  logic        cancel;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;
  logic [63:0] exp_q[$];

  muldiv_seq dut (
    .clk(clk), .nrst(nrst), .md_op(md_op), .md_start(md_start),
    .rs(rs), .rt(rt), .cancel(cancel),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Result as {hi, lo} from the architectural definition of each op.
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return 64'(ua * ub);
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == OP_DIV) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (nrst && done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("result_hi", {32'd0, hi}, {32'd0, e[63:32]});
        check("result_lo", {32'd0, lo}, {32'd0, e[31:0]});
      end
    end
  end

  // Called at a negedge; returns just after the accepting posedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op    = op;
    rs       = a;
    rt       = b;
    md_start = 1'b1;
    @(posedge clk);
    #1;
    md_start = 1'b0;
    md_op    = OP_NONE;
  endtask

  // Called at a negedge; returns at the negedge where done is observed.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    int n;
    bit got;
    n   = 0;
    got = 0;
    exp_q.push_back(exp);
    issue(op, a, b);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
      if (busy) n++;
    end
    check("done_seen", 64'(got), 64'd1);
    check("busy_cycles", 64'(n), 64'd33);
    check("busy_at_done", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [31:0] a, b, save_hi, save_lo;
    logic [2:0]  op;
    int          d0;
    bit          got;

    nrst = 1'b0; md_op = OP_NONE; md_start = 1'b0; rs = '0; rt = '0; cancel = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    nrst = 1'b1;
    @(negedge clk);

    // directed arithmetic cases, back to back
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op(OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(OP_DIVU,  32'hFFFF_FFF9, 32'h0000_0002, 64'h0000_0001_7FFF_FFFC);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    run_op(OP_DIVU,  32'h1234_5678, 32'h0000_0000, 64'h1234_5678_FFFF_FFFF);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 64'hFFFF_FFF9_FFFF_FFFF);

    // MTHI / MTLO take effect at the next edge without busy or done
    @(negedge clk);
    issue(OP_MTHI, 32'hAAAA_5555, 32'h0);
    check("mthi_hi", {32'd0, hi}, 64'h0000_0000_AAAA_5555);
    check("mthi_busy", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    issue(OP_MTLO, 32'h5555_AAAA, 32'h0);
    check("mtlo_lo", {32'd0, lo}, 64'h0000_0000_5555_AAAA);
    check("mtlo_busy", {62'd0, busy, done}, 64'd0);

    // MTHI while busy is ignored
    @(negedge clk);
    exp_q.push_back(64'd30);
    issue(OP_MULT, 32'd5, 32'd6);
    repeat (5) @(negedge clk);
    md_op = OP_MTHI; rs = 32'hDEAD_BEEF; md_start = 1'b1;
    @(posedge clk);
    #1;
    md_start = 1'b0;
    check("mthi_while_busy", {32'd0, hi}, 64'h0000_0000_AAAA_5555);
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    check("done_after_ignored_mthi", 64'(got), 64'd1);

    // cancel together with md_start in IDLE drops the request
    @(negedge clk);
    md_op = OP_MTLO; rs = 32'h0000_0001; md_start = 1'b1; cancel = 1'b1;
    @(posedge clk);
    #1;
    md_start = 1'b0; cancel = 1'b0;
    check("cancel_idle_lo", {32'd0, lo}, 64'd30);

    // cancel mid-MULT: busy drops, no done, hi/lo untouched
    @(negedge clk);
    save_hi = 32'd0; save_lo = 32'd30;
    issue(OP_MULT, 32'd12345, 32'd678);
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    check("cancel_busy", {63'd0, busy}, 64'd0);
    d0 = done_seen;
    repeat (40) @(negedge clk);
    check("cancel_no_done", 64'(done_seen), 64'(d0));
    check("cancel_hilo", {hi, lo}, {save_hi, save_lo});

    // asynchronous reset mid-DIV
    issue(OP_DIV, 32'd1000, 32'd7);
    repeat (15) @(negedge clk);
    nrst = 1'b0;
    #1;
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    check("rst_mid_busy", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(1, 4));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'h8000_0000;
        default: ;
      endcase
      run_op(op, a, b, ref_md(op, a, b));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
